sd_arbiter: RTL

- Shares the single SD-card block interface between floppy (IWM) and SCSI image requesters.
- Replaces the ad-hoc scsi_io/scsi_dev toggle demux in the Mac Plus data controller.
- Latches single-cycle read/write requests and grants them round-robin.
- Drives sdc_lba/sdc_rd/sdc_wr for the owner, routes busy/ack and buffer strobes to the owner only, suppresses writes to protected images, and stretches per-device activity LEDs.

---
 rtl/sd_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sd_arbiter.sv
// Round-robin owner of the shared SD block interface for floppy and SCSI image requesters.
// Latches request pulses, issues one transfer at a time and routes status only to the owner.
module sd_arbiter #(
    parameter int NDEV     = 4,
    parameter int TIMEOUT  = 1024,
    parameter int LED_HOLD = 65535
) (
    input  logic                    clk,
    input  logic                    _reset,
    input  logic [NDEV-1:0]         req_rd,
    input  logic [NDEV-1:0]         req_wr,
    input  logic [32*NDEV-1:0]      req_lba,
    input  logic [8*NDEV-1:0]       req_dout,
    input  logic [NDEV-1:0]         wprot,
    output logic [NDEV-1:0]         req_ack,
    output logic [NDEV-1:0]         req_data_en,
    output logic [$clog2(NDEV)-1:0] owner,
    output logic [31:0]             sdc_lba,
    output logic [NDEV-1:0]         sdc_rd,
    output logic [NDEV-1:0]         sdc_wr,
    input  logic                    sdc_busy,
    input  logic                    sdc_done,
    input  logic                    sdc_data_en,
    output logic [7:0]              sdc_data_out,
    output logic [NDEV-1:0]         led,
    output logic [7:0]              abort_cnt
);
    localparam int OW = $clog2(NDEV);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LED_HOLD + 1);
    localparam logic [NDEV-1:0] ONE = NDEV'(1);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_ISSUE, S_XFER, S_DONE} state_t;

    state_t          r_state;
    logic [OW-1:0]   r_owner;
    logic [31:0]     r_lba;
    logic [NDEV-1:0] r_rd;
    logic [NDEV-1:0] r_wr;
    logic            r_tmo_ack;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      r_abort;

    logic [NDEV-1:0] w_pending;
    logic [NDEV-1:0] w_kind;
    logic [31:0]     w_lba [NDEV];
    logic [7:0]      w_dout [NDEV];
    logic [NDEV-1:0] w_owner_oh;
    logic            w_prot;
    logic            w_found;
    logic [OW-1:0]   w_winner;
    int              w_best;

    // Distance from the current owner; the owner itself ranks last.
    function automatic int rr_dist(input int j, input int o);
        return (j > o) ? (j - o) : (j + NDEV - o);
    endfunction

    generate
        for (genvar gi = 0; gi < NDEV; gi++) begin : g_dev
            logic          r_pend;
            logic          r_kind;
            logic [LW-1:0] r_led_cnt;

            assign w_lba[gi]  = req_lba[32*gi +: 32];
            assign w_dout[gi] = req_dout[8*gi +: 8];

            always_ff @(posedge clk or negedge _reset) begin
                if (!_reset) begin
                    r_pend <= 1'b0;
                    r_kind <= 1'b0;
                end else if (r_state == S_LATCH && r_owner == OW'(gi)) begin
                    r_pend <= 1'b0;
                end else if (!r_pend && !(r_state != S_IDLE && r_owner == OW'(gi))
                             && (req_rd[gi] || req_wr[gi])) begin
                    r_pend <= 1'b1;
                    r_kind <= ~req_rd[gi];
                end
            end

            always_ff @(posedge clk or negedge _reset) begin
                if (!_reset) begin
                    r_led_cnt <= '0;
                end else if (r_state == S_LATCH && r_owner == OW'(gi)) begin
                    r_led_cnt <= LW'(LED_HOLD);
                end else if (r_led_cnt != '0) begin
                    r_led_cnt <= r_led_cnt - LW'(1);
                end
            end

            assign w_pending[gi] = r_pend;
            assign w_kind[gi]    = r_kind;
            assign led[gi]       = (r_led_cnt != '0);
        end
    endgenerate

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_owner;
        w_best   = NDEV + 1;
        for (int j = 0; j < NDEV; j++) begin
            if (w_pending[j] && rr_dist(j, int'(r_owner)) < w_best) begin
                w_best   = rr_dist(j, int'(r_owner));
                w_winner = OW'(j);
                w_found  = 1'b1;
            end
        end
    end

    assign w_owner_oh = ONE << r_owner;
    assign w_prot     = w_kind[r_owner] & wprot[r_owner];

    // The LBA is captured at grant so it is already settled during LATCH, a cycle ahead of the strobe.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_lba     <= '0;
            r_rd      <= '0;
            r_wr      <= '0;
            r_tmo_ack <= 1'b0;
            r_tmo     <= '0;
            r_abort   <= '0;
        end else begin
            r_tmo_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_winner;
                        r_lba   <= w_lba[w_winner];
                        r_state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    if (w_prot) begin
                        r_state <= S_DONE;
                    end else begin
                        r_tmo   <= '0;
                        r_state <= S_ISSUE;
                        if (w_kind[r_owner]) r_wr <= w_owner_oh;
                        else                 r_rd <= w_owner_oh;
                    end
                end
                S_ISSUE: begin
                    if (sdc_busy) begin
                        r_rd    <= '0;
                        r_wr    <= '0;
                        r_state <= S_XFER;
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_rd      <= '0;
                        r_wr      <= '0;
                        r_tmo_ack <= 1'b1;
                        if (r_abort != 8'hFF) r_abort <= r_abort + 8'd1;
                        r_state   <= S_DONE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_XFER: begin
                    if (sdc_done || !sdc_busy) r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ack = w_owner_oh & {NDEV{(r_state == S_XFER && sdc_busy)
                                        || (r_state == S_LATCH && w_prot)
                                        || r_tmo_ack}};
    assign req_data_en  = w_owner_oh & {NDEV{sdc_data_en && r_state == S_XFER}};
    assign sdc_data_out = w_dout[r_owner];
    assign owner        = r_owner;
    assign sdc_lba      = r_lba;
    assign sdc_rd       = r_rd;
    assign sdc_wr       = r_wr;
    assign abort_cnt    = r_abort;

endmodule
